// File: rtl/dvb_s2_axis_frame_align_if.sv
// AXI-stream bus bundle for the DVB-S2 frame aligner: data, end-of-frame and TID/TDEST/TUSER sideband.
interface dvb_s2_axis_frame_align_if #(
  parameter int pDAT_W   = 8,
  parameter int pTID_W   = 8,
  parameter int pTDEST_W = 4,
  parameter int pTUSER_W = 9
);
  logic                tvalid;
  logic                tready;
  logic [pDAT_W-1:0]   tdata;
  logic                tlast;
  logic [pTID_W-1:0]   tid;
  logic [pTDEST_W-1:0] tdest;
  logic [pTUSER_W-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/dvb_s2_axis_frame_align.sv
// Forces each AXI-stream frame to exactly len beats (pad short / truncate long) ahead of the LDPC encoder.
// One register stage (accept at t -> m_axis_tvalid at t+1); s_axis_tready is combinational from m_axis_tready and low while padding.
module dvb_s2_axis_frame_align #(
  parameter int pDAT_W   = 8,
  parameter int pTID_W   = 8,
  parameter int pTDEST_W = 4,
  parameter int pTUSER_W = 9,
  parameter int pLEN_W   = 16,
  parameter bit pPAD_EN  = 1'b1
) (
  input  logic                     iclk,
  input  logic                     iresetn,
  input  logic [pLEN_W-1:0]        ilen,
  dvb_s2_axis_frame_align_if.slave  s_axis,
  dvb_s2_axis_frame_align_if.master m_axis,
  output logic                     obusy,
  output logic                     oframe_done,
  output logic [pLEN_W-1:0]        oframe_beatnum,
  output logic                     oframe_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [pLEN_W-1:0] LEN_ONE = {{(pLEN_W-1){1'b0}}, 1'b1};
  localparam logic [pLEN_W-1:0] LEN_MAX = '1;

  logic [1:0]          state;
  logic [pLEN_W-1:0]   len;
  logic [pLEN_W-1:0]   ocnt;
  logic [pLEN_W-1:0]   icnt;

  logic                out_vld;
  logic                out_last;
  logic [pDAT_W-1:0]   out_dat;
  logic [pTID_W-1:0]   tid_q;
  logic [pTDEST_W-1:0] tdest_q;
  logic [pTUSER_W-1:0] tuser_q;

  logic                out_free;
  logic                s_rdy;
  logic                s_fire;
  logic                is_idle;
  logic [pLEN_W-1:0]   len_now;
  logic [pLEN_W-1:0]   ocnt_now;
  logic [pLEN_W-1:0]   icnt_now;
  logic                at_len;
  logic                pass_last;
  logic                pass_err;
  logic [1:0]          pass_next;
  logic                pad_last;

  always_comb begin
    out_free = !out_vld || m_axis.tready;
    case (state)
      ST_IDLE, ST_PASS: s_rdy = out_free;
      ST_DROP:          s_rdy = 1'b1;
      default:          s_rdy = 1'b0;
    endcase
    s_fire  = s_axis.tvalid && s_rdy;
    is_idle = (state == ST_IDLE);

    // A first beat is judged against the length being sampled right now, not the stale latch.
    len_now  = is_idle ? ((ilen == '0) ? LEN_ONE : ilen) : len;
    ocnt_now = is_idle ? LEN_ONE : ocnt + LEN_ONE;
    icnt_now = is_idle ? LEN_ONE : ((icnt == LEN_MAX) ? icnt : icnt + LEN_ONE);
    at_len   = (ocnt_now == len_now);

    pass_last = 1'b0;
    pass_err  = 1'b0;
    pass_next = ST_PASS;
    if (s_axis.tlast) begin
      pass_err = !at_len;
      if (at_len || !pPAD_EN) begin
        pass_last = 1'b1;
        pass_next = ST_IDLE;
      end else begin
        pass_next = ST_PAD;
      end
    end else if (at_len) begin
      pass_last = 1'b1;
      pass_next = ST_DROP;
    end

    pad_last = ((ocnt + LEN_ONE) == len);
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state          <= ST_IDLE;
      len            <= '0;
      ocnt           <= '0;
      icnt           <= '0;
      tid_q          <= '0;
      tdest_q        <= '0;
      tuser_q        <= '0;
      oframe_done    <= 1'b0;
      oframe_beatnum <= '0;
      oframe_error   <= 1'b0;
    end else begin
      oframe_done <= 1'b0;
      case (state)
        ST_IDLE, ST_PASS: begin
          if (s_fire) begin
            if (is_idle) begin
              len     <= len_now;
              tid_q   <= s_axis.tid;
              tdest_q <= s_axis.tdest;
              tuser_q <= s_axis.tuser;
            end
            ocnt  <= ocnt_now;
            icnt  <= icnt_now;
            state <= pass_next;
            if (s_axis.tlast) begin
              oframe_done    <= 1'b1;
              oframe_beatnum <= icnt_now;
              oframe_error   <= pass_err;
            end
          end
        end
        ST_PAD: begin
          if (out_free) begin
            ocnt <= ocnt + LEN_ONE;
            if (pad_last) state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (s_fire) begin
            icnt <= icnt_now;
            if (s_axis.tlast) begin
              state          <= ST_IDLE;
              oframe_done    <= 1'b1;
              oframe_beatnum <= icnt_now;
              oframe_error   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: reloads in the same cycle the consumer takes the previous beat.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
    end else if (s_fire && state != ST_DROP) begin
      out_vld  <= 1'b1;
      out_last <= pass_last;
      out_dat  <= s_axis.tdata;
    end else if (state == ST_PAD && out_free) begin
      out_vld  <= 1'b1;
      out_last <= pad_last;
      out_dat  <= '0;
    end else if (m_axis.tready) begin
      out_vld  <= 1'b0;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_last;
  assign m_axis.tdata  = out_dat;
  assign m_axis.tid    = tid_q;
  assign m_axis.tdest  = tdest_q;
  assign m_axis.tuser  = tuser_q;
  assign obusy         = (state != ST_IDLE) || out_vld;

endmodule

// File: doc/dvb_s2_axis_frame_align.md
# dvb_s2_axis_frame_align

Parametrised AXI-stream frame aligner between the DVB-S2 transport/BB-frame source and the LDPC encoder input. It forces every frame to an exact beat length, sampled per frame: short frames are zero-padded, long frames are truncated. It reports per-frame status (done, received length, error) and carries TID/TDEST/TUSER sideband, latched at frame start, across the whole frame. It generalises the fixed 8-bit encoder input path to any data/sideband width and any frame length.

## Interface
- pDAT_W, 8: tdata width in bits, ≥1.
- pTID_W, 8: tid width.
- pTDEST_W, 4: tdest width.
- pTUSER_W, 9: tuser width.
- pLEN_W, 16: frame length/counter width in beats.
- pPAD_EN, 1: 1 = zero-pad short frames to ilen; 0 = forward short frames unpadded (still flagged).

Ports:
- iclk  in  1  clock.
- iresetn  in  1  reset: asynchronous, active-low.
- ilen  in  pLEN_W  expected frame length in beats; sampled on the first accepted beat of each frame; 0 treated as 1.
- s_axis_tvalid/tready  in/out  1  input handshake.
- s_axis_tdata  in  pDAT_W  input data.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tid / tdest / tuser  in  pTID_W / pTDEST_W / pTUSER_W  sideband; sampled on the first beat only.
- m_axis_tvalid/tready  out/in  1  output handshake.
- m_axis_tdata  out  pDAT_W  output data; zero on pad beats.
- m_axis_tlast  out  1  asserted exactly on output beat number len.
- m_axis_tid / tdest / tuser  out  widths as input  latched frame sideband, constant for all beats of a frame.
- obusy  out  1  state≠IDLE or m_axis_tvalid.
- oframe_done  out  1  one-cycle status strobe per input frame.
- oframe_beatnum  out  pLEN_W  input beats received in the frame; saturates at 2^pLEN_W−1.
- oframe_error  out  1  received length ≠ len; valid with oframe_done.

## Operation
- Counters:
  - ocnt: output beats issued in the current frame, 1..len.
  - icnt: saturating count of input beats received.
  - len: latched ilen, with 0 mapped to 1.
- Output stage is one register. out_free = !m_axis_tvalid | m_axis_tready.
- s_axis_tready:
  - IDLE/PASS: out_free.
  - DROP: 1.
  - PAD: 0.
- IDLE:
  - On an accepted beat: latch len and sideband, and load the output register with that beat.
  - Then apply the PASS rules, with ocnt=1.
- PASS, on each accepted beat with new ocnt:
  - tlast & ocnt==len: tlast_out=1, error=0, go to IDLE.
  - tlast & ocnt<len, pPAD_EN=1: tlast_out=0, error=1, go to PAD.
  - tlast & ocnt<len, pPAD_EN=0: tlast_out=1, error=1, go to IDLE.
  - !tlast & ocnt==len: tlast_out=1, error=1, go to DROP.
  - Otherwise: tlast_out=0, stay in PASS.
- PAD:
  - On each out_free, issue a beat with tdata=0.
  - On the beat where ocnt==len: tlast_out=1, go to IDLE.
- DROP:
  - Discard input beats (tready=1). They count into icnt only.
  - On the accepted tlast, go to IDLE.
- oframe_done strobe: the cycle after the input beat carrying the frame's end event is accepted. That beat is the tlast in PASS/DROP, or the short tlast that enters PAD.
  - oframe_beatnum = icnt, held until the next strobe.
  - oframe_error set as listed above.
- The next frame is not accepted until the FSM is back in IDLE, so PAD backpressures the input.
- Reset values:
  - FSM=IDLE; all counters 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tid/tdest/tuser=0.
  - oframe_done=0, oframe_beatnum=0, oframe_error=0, obusy=0.
- Reset mid-frame: the frame is aborted, with no oframe_done strobe. Output returns to the reset values asynchronously.

## Timing
- Latency: an input beat accepted at cycle t gives m_axis_tvalid high at t+1.
- Throughput: one beat per cycle under m_axis_tready=1, with no bubbles between frames; IDLE accepts in the same cycle.
- Output holds tdata/tlast/sideband stable while tvalid & !tready.
- The s_axis_tready path is combinational from m_axis_tready through out_free.
- Simultaneous m_axis_tready and a new input beat: the register is reloaded in the same cycle.
- Saturation: icnt stops at all-ones, while ocnt still truncates at len.

## Test plan
- Exact frame: ilen=4, send 4 beats 0x11..0x44 with tlast on beat 4, m_axis_tready=1. Expect 4 output beats at +1 cycle, tlast on beat 4, done with beatnum=4, error=0.
- Short frame, pPAD_EN=1: ilen=6, send 3 beats with tlast. Expect outputs 3 data beats + 3 zero beats, tlast on beat 6. s_axis_tready=0 during PAD. done with beatnum=3, error=1.
- Long frame: ilen=3, send 5 beats with tlast on beat 5. Expect 3 output beats, tlast on beat 3; beats 4-5 accepted and dropped. beatnum=5, error=1.
- Backpressure and sideband: ilen=4, tid=0xA5 on beat 1 and 0x00 on later beats; m_axis_tready toggles 1,0,0,1. Expect data held stable while stalled, m_axis_tid=0xA5 on all 4 beats, no loss or duplication.
- Edge cases:
  - ilen=0: a single tlast beat gives one output beat with tlast, error=0.
  - pPAD_EN=0 short frame (ilen=5, 2 beats): 2 output beats, tlast on beat 2, error=1.
- Reset mid-frame: assert iresetn=0 after beat 2 of a 4-beat frame. Expect m_axis_tvalid=0 immediately, no done strobe. The next frame after release processes normally.
